// File: rtl/exec_unit.sv
// Decode/execute stage of the 8-bit CPU: one instruction per valid/ready handshake,
// A/B registers with Z/C flags, data-memory port and jump redirects back to fetch.
module exec_unit #(
  parameter int          RD_LAT = 1,
  parameter logic [7:0]  A_RST  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inst_valid,
  input  logic [7:0] inst,
  output logic       inst_ready,
  output logic       pc_load,
  output logic [7:0] pc_target,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic [7:0] a_out,
  output logic [1:0] flags,
  output logic       halted
);

  // Handshake: an instruction transfers on a rising edge where inst_valid and
  // inst_ready are both high; inst_ready is high only in IDLE and out of reset.
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEMRD, S_HALT} state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LDA = 4'h2, OP_STA = 4'h3,
                         OP_MOV = 4'h4, OP_ADD = 4'h5, OP_SUB = 4'h6, OP_AND = 4'h7,
                         OP_OR  = 4'h8, OP_XOR = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB,
                         OP_JC  = 4'hC, OP_SHL = 4'hD, OP_LDH = 4'hE, OP_HLT = 4'hF;

  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic [7:0] ir_q, ir_d;
  logic [1:0] cnt_q, cnt_d;
  logic       a_wr;
  logic [8:0] wide;

  logic [3:0] op;
  logic [3:0] imm;
  assign op  = ir_q[7:4];
  assign imm = ir_q[3:0];

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    z_d        = z_q;
    c_d        = c_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    a_wr       = 1'b0;
    wide       = 9'h000;
    inst_ready = 1'b0;
    pc_load    = 1'b0;
    mem_addr   = 8'h00;
    mem_wdata  = 8'h00;
    mem_we     = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_IDLE: begin
        inst_ready = rst_n;
        if (inst_valid) begin
          ir_d    = inst;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        case (op)
          OP_NOP: ;
          OP_LDI: begin a_d = {4'h0, imm}; a_wr = 1'b1; end
          OP_LDA: begin
            mem_addr = b_q;
            cnt_d    = 2'd0;
            state_d  = S_MEMRD;
          end
          OP_STA: begin
            mem_addr  = b_q;
            mem_wdata = a_q;
            mem_we    = 1'b1;
          end
          OP_MOV: b_d = a_q;
          OP_ADD: begin
            wide = {1'b0, a_q} + {1'b0, b_q};
            {c_d, a_d} = wide;
            a_wr = 1'b1;
          end
          OP_SUB: begin
            // Bit 8 of the 9-bit difference is the borrow.
            wide = {1'b0, a_q} - {1'b0, b_q};
            {c_d, a_d} = wide;
            a_wr = 1'b1;
          end
          OP_AND: begin a_d = a_q & b_q; a_wr = 1'b1; end
          OP_OR:  begin a_d = a_q | b_q; a_wr = 1'b1; end
          OP_XOR: begin a_d = a_q ^ b_q; a_wr = 1'b1; end
          OP_JMP: pc_load = 1'b1;
          OP_JZ:  pc_load = z_q;
          OP_JC:  pc_load = c_q;
          OP_SHL: begin
            c_d  = a_q[7];
            a_d  = {a_q[6:0], 1'b0};
            a_wr = 1'b1;
          end
          OP_LDH: begin a_d = {imm, a_q[3:0]}; a_wr = 1'b1; end
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_MEMRD: begin
        mem_addr = b_q;
        if (cnt_q == CNT_LAST) begin
          a_d     = mem_rdata;
          a_wr    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (a_wr) z_d = (a_d == 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= A_RST;
      b_q     <= 8'h00;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      ir_q    <= 8'h00;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      c_q     <= c_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_target = b_q;
  assign a_out     = a_q;
  assign flags     = {z_q, c_q};

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed instruction streams against a transaction-level
// model of the A/B/Z/C machine, checked every cycle, plus literal spot checks.
module tb_exec_unit;

  localparam int         RD_LAT = 2;
  localparam logic [7:0] A_RST  = 8'h3C;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       inst_valid;
  logic [7:0] inst;
  logic       inst_ready, pc_load, mem_we, halted;
  logic [7:0] pc_target, mem_addr, mem_wdata, mem_rdata, a_out;
  logic [1:0] flags;

  always #5 clk = ~clk;

  exec_unit #(.RD_LAT(RD_LAT), .A_RST(A_RST)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .pc_load(pc_load), .pc_target(pc_target),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .a_out(a_out), .flags(flags), .halted(halted)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- data memory environment ----------------
  logic [7:0] env_mem [256];
  logic [7:0] rd_pipe [3];
  always @(posedge clk) begin
    rd_pipe[0] <= env_mem[mem_addr];
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // ---------------- model state ----------------
  logic [7:0]  m_a, m_b;
  logic        m_z, m_c;
  logic [7:0]  mdl_mem [256];
  logic        e_ready, e_we, e_pcl, e_addr_v, e_halt;
  logic        chk_en;
  logic [15:0] exp_q[$];

  int          cyc = 0;
  int          acc_q[$];
  int          we_cnt = 0, pcl_cnt = 0;
  logic [15:0] last_w;
  logic [7:0]  last_tgt;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard / monitors ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("inst_ready", 16'(inst_ready), 16'(e_ready));
      chk("a_out", 16'(a_out), 16'(m_a));
      chk("flags", 16'(flags), 16'({m_z, m_c}));
      chk("halted", 16'(halted), 16'(e_halt));
      chk("mem_we", 16'(mem_we), 16'(e_we));
      chk("pc_load", 16'(pc_load), 16'(e_pcl));
      if (e_pcl)    chk("pc_target", 16'(pc_target), 16'(m_b));
      if (e_addr_v) chk("mem_addr", 16'(mem_addr), 16'(m_b));
      if (e_we)     chk("mem_wdata", 16'(mem_wdata), 16'(m_a));
    end
    if (rst_n && inst_valid && inst_ready) acc_q.push_back(cyc);
    if (rst_n && pc_load) begin
      pcl_cnt++;
      last_tgt = pc_target;
    end
    if (rst_n && mem_we) begin
      we_cnt++;
      last_w = {mem_addr, mem_wdata};
      env_mem[mem_addr] = mem_wdata;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mem_write_unexpected: got %h expected none", {mem_addr, mem_wdata});
      end else begin
        chk("mem_write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- model ----------------
  task automatic model_reset();
    m_a = A_RST; m_b = 8'h00; m_z = 1'b0; m_c = 1'b0;
    e_ready = 1'b1; e_we = 1'b0; e_pcl = 1'b0; e_addr_v = 1'b0; e_halt = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_a(input int v);
    m_a = 8'(v % 256);
    m_z = (m_a == 8'h00);
  endtask

  task automatic apply(input logic [3:0] op, input logic [3:0] imm);
    int s;
    case (op)
      4'h1: set_a(int'(imm));
      4'h4: m_b = m_a;
      4'h5: begin s = int'(m_a) + int'(m_b); m_c = (s > 255); set_a(s); end
      4'h6: begin m_c = (m_a < m_b); set_a(int'(m_a) - int'(m_b) + 256); end
      4'h7: set_a(int'(m_a & m_b));
      4'h8: set_a(int'(m_a | m_b));
      4'h9: set_a(int'(m_a ^ m_b));
      4'hD: begin m_c = (m_a >= 8'h80); set_a(int'(m_a) * 2); end
      4'hE: set_a(int'(imm) * 16 + int'(m_a) % 16);
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 with the stage idle (or halted).
  task automatic issue(input logic [7:0] ins);
    logic [3:0] op;
    op = ins[7:4];
    inst = ins;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    inst = 8'h00;
    e_ready  = 1'b0;
    e_we     = (op == 4'h3);
    e_addr_v = (op == 4'h2) || (op == 4'h3);
    e_pcl    = (op == 4'hA) || (op == 4'hB && m_z) || (op == 4'hC && m_c);
    if (op == 4'h3) begin
      mdl_mem[m_b] = m_a;
      exp_q.push_back({m_b, m_a});
    end
    @(posedge clk); #1;
    e_we  = 1'b0;
    e_pcl = 1'b0;
    if (op == 4'h2) begin
      repeat (RD_LAT) begin @(posedge clk); #1; end
      set_a(int'(mdl_mem[m_b]));
      e_addr_v = 1'b0;
      e_ready  = 1'b1;
    end else if (op == 4'hF) begin
      e_addr_v = 1'b0;
      e_halt   = 1'b1;
    end else begin
      e_addr_v = 1'b0;
      apply(op, ins[3:0]);
      e_ready = 1'b1;
    end
  endtask

  task automatic run(input logic [7:0] prog[$]);
    foreach (prog[i]) issue(prog[i]);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    inst_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", 16'(a_out), 16'(8'h3C));
    chk("rst_flags", 16'(flags), 16'h0);
    chk("rst_ready", 16'(inst_ready), 16'h0);
    chk("rst_outs", 16'({halted, mem_we, pc_load}), 16'h0);
    chk("rst_mem", {mem_addr, mem_wdata}, 16'h0000);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 16'(inst_ready), 16'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 8'(i) ^ 8'hA5;
      mdl_mem[i] = 8'(i) ^ 8'hA5;
    end
    inst = 8'h00;
    do_reset();

    // LDI 5; MOV; LDI 3; ADD
    run('{8'h15, 8'h40, 8'h13, 8'h50});
    chk("t1_a", 16'(a_out), 16'h08);
    chk("t1_flags", 16'(flags), 16'h0);
    chk("t1_accept_gap", 16'(acc_q[$] - acc_q[$-1]), 16'd2);

    // LDI F; LDH F; MOV; ADD -> FE carry; MOV; SUB -> 0
    run('{8'h1F, 8'hEF, 8'h40, 8'h50});
    chk("t2_add_a", 16'(a_out), 16'hFE);
    chk("t2_add_flags", 16'(flags), 16'b01);
    run('{8'h40, 8'h60});
    chk("t2_sub_a", 16'(a_out), 16'h00);
    chk("t2_sub_flags", 16'(flags), 16'b10);

    // B=20, A=5A; STA; clear A; LDA
    run('{8'h10, 8'hE2, 8'h40, 8'h1A, 8'hE5, 8'h30, 8'h10, 8'h20});
    chk("t3_we_cnt", 16'(we_cnt), 16'd1);
    chk("t3_write", last_w, 16'h205A);
    chk("t3_lda_a", 16'(a_out), 16'h5A);

    // B=40, Z=1: JZ taken; Z=0: JZ not taken
    run('{8'h10, 8'hE4, 8'h40, 8'h10, 8'hB0});
    chk("t4_jz_cnt", 16'(pcl_cnt), 16'd1);
    chk("t4_jz_tgt", 16'(last_tgt), 16'h40);
    run('{8'h11, 8'hB0});
    chk("t4_jz_nt_cnt", 16'(pcl_cnt), 16'd1);

    // logic ops, SHL carry, JC, JMP, NOP, LDA from preloaded memory, SUB borrow
    run('{8'h13, 8'h80, 8'h70, 8'h90});
    chk("t5_logic_a", 16'(a_out), 16'h00);
    run('{8'h10, 8'hE8, 8'hD0});
    chk("t5_shl_flags", 16'({flags, a_out}), 16'h300);
    run('{8'hC0, 8'hA0, 8'h00});
    chk("t5_jumps", 16'(pcl_cnt), 16'd3);
    run('{8'h20});
    chk("t5_lda_pre", 16'({flags, a_out}), 16'h1E5);
    run('{8'h11, 8'h60});
    chk("t5_borrow", 16'({flags, a_out}), 16'h1C1);

    // HLT, then hold a valid instruction for 20 cycles
    issue(8'hF0);
    inst = 8'h17;
    inst_valid = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    chk("t6_halted", 16'({halted, inst_ready}), 16'b10);
    chk("t6_a", 16'(a_out), 16'hC1);
    inst_valid = 1'b0;
    do_reset();

    // reset while an LDA is waiting on memory
    run('{8'h17, 8'hE3, 8'h40});
    inst = 8'h20;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    e_ready = 1'b0;
    e_addr_v = 1'b1;
    @(posedge clk); #1;
    chk("t7_memrd_addr", 16'(mem_addr), 16'h37);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_a", 16'(a_out), 16'(8'h3C));
    chk("t7_rst_addr", 16'(mem_addr), 16'h00);
    chk("t7_rst_ready", 16'(inst_ready), 16'h0);
    do_reset();
    run('{8'h19});
    chk("t7_after_a", 16'(a_out), 16'h09);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
